// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: default field width and FSM state encoding.
package pulse_gen_pkg;

    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable saturating down counter with zero flag; used for phase timing and remaining-pulse tracking.
module down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Generates a train of 'count' pulses, each 'width' cycles high separated by 'gap' low cycles,
// with abort, a completion strobe and registered outputs.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] gap,
    input  logic [CW-1:0] count,
    input  logic          abort,
    output logic          pulse,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_width;
    logic [CW-1:0] r_gap;
    logic          r_pulse;
    logic          r_busy;
    logic          r_done;
    logic          r_ready;

    logic          w_accept;
    logic          w_ph_load;
    logic [CW-1:0] w_ph_val;
    logic          w_ph_en;
    logic          w_ph_zero;
    logic          w_np_load;
    logic          w_np_en;
    logic          w_np_zero;

    // Phase counters hold (length - 1); a zero length behaves as one cycle.
    function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] v);
        return (v == '0) ? '0 : (v - CW'(1));
    endfunction

    assign w_accept  = start && (r_state == IDLE);
    assign w_np_load = w_accept && (count != '0);

    down_counter #(.W(CW)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_en       (w_ph_en),
        .o_zero     (w_ph_zero)
    );

    // Holds the number of pulses still to come after the current one.
    down_counter #(.W(CW)) u_pulses (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_np_load),
        .i_load_val (count - CW'(1)),
        .i_en       (w_np_en),
        .o_zero     (w_np_zero)
    );

    // Next-state and counter control.
    always_comb begin
        w_next    = r_state;
        w_ph_load = 1'b0;
        w_ph_val  = '0;
        w_ph_en   = 1'b0;
        w_np_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_next    = HIGH;
                        w_ph_load = 1'b1;
                        w_ph_val  = len_m1(width);
                    end else begin
                        w_next = FIN;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            HIGH: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_ph_zero) begin
                    if (w_np_zero) begin
                        w_next = FIN;
                    end else begin
                        w_next    = LOW;
                        w_np_en   = 1'b1;
                        w_ph_load = 1'b1;
                        w_ph_val  = len_m1(r_gap);
                    end
                end else begin
                    w_ph_en = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_ph_zero) begin
                    w_next    = HIGH;
                    w_ph_load = 1'b1;
                    w_ph_val  = len_m1(r_width);
                end else begin
                    w_ph_en = 1'b1;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            r_pulse <= (w_next == HIGH);
            r_busy  <= (w_next == HIGH) || (w_next == LOW);
            r_done  <= (w_next == FIN);
            r_ready <= (w_next == IDLE);
        end
    end

    // Width and gap are captured at acceptance so later input changes do not disturb the train.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_width <= '0;
            r_gap   <= '0;
        end else if (w_accept) begin
            r_width <= width;
            r_gap   <= gap;
        end else begin
            r_width <= r_width;
            r_gap   <= r_gap;
        end
    end

    assign pulse = r_pulse;
    assign busy  = r_busy;
    assign done  = r_done;
    assign ready = r_ready;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench: expected waveforms are built from the train rules (pulse/gap lengths, done, abort, reset).
module tb_pulse_train_generator;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] width;
    logic [CW-1:0] gap;
    logic [CW-1:0] count;
    logic          ready;
    logic          pulse;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic pulse;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    always #5 clk = ~clk;

    pulse_train_generator #(.CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .width (width),
        .gap   (gap),
        .count (count),
        .abort (abort),
        .pulse (pulse),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [3:0] exp_v);
        logic [3:0] obs;
        obs = {pulse, busy, done, ready};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed pulse,busy,done,ready=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one train; abort_at/rst_at index the post-acceptance cycle during which abort/reset is driven (-1 = never).
    task automatic run_train(input string tag, input int w, input int g, input int c,
                             input int abort_at, input int rst_at, input bit abort_on_accept);
        exp_t q[$];
        int   wl;
        int   gl;
        bit   cut;
        wl = (w == 0) ? 1 : w;
        gl = (g == 0) ? 1 : g;
        for (int p = 0; p < c; p++) begin
            for (int k = 0; k < wl; k++) q.push_back(4'b1100);
            if (p < c - 1) begin
                for (int k = 0; k < gl; k++) q.push_back(4'b0100);
            end
        end
        q.push_back(4'b0010);
        q.push_back(4'b0001);

        start = 1'b1;
        width = CW'(w);
        gap   = CW'(g);
        count = CW'(c);
        abort = abort_on_accept;
        rst   = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i), q[i]);
            if (i == q.size() - 1) break;
            cut   = (i == rst_at) || ((i == abort_at) && q[i].busy);
            abort = (i == abort_at);
            rst   = (i == rst_at) ? 1'b0 : 1'b1;
            start = q[i].ready ? 1'b0 : 1'($urandom_range(0, 1));
            width = CW'($urandom);
            gap   = CW'($urandom);
            count = CW'($urandom);
            cyc();
            if (cut) begin
                start = 1'b0;
                abort = 1'b0;
                rst   = 1'b1;
                chk($sformatf("%s_cut", tag), 4'b0001);
                cyc();
                chk($sformatf("%s_cut_nodone", tag), 4'b0001);
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        int w;
        int g;
        int c;
        int len;
        int ab;
        start = 1'b0;
        abort = 1'b0;
        width = '0;
        gap   = '0;
        count = '0;
        rst   = 1'b0;
        cyc();
        cyc();
        chk("reset", 4'b0001);

        // Reset wins over a simultaneous start.
        rst   = 1'b0;
        start = 1'b1;
        count = CW'(3);
        width = CW'(2);
        cyc();
        chk("reset_over_start", 4'b0001);
        rst   = 1'b1;
        start = 1'b0;
        cyc();
        chk("idle_after_reset", 4'b0001);

        run_train("w1g1c3", 1, 1, 3, -1, -1, 1'b0);
        run_train("w3g2c2", 3, 2, 2, -1, -1, 1'b0);
        run_train("c0", 5, 5, 0, -1, -1, 1'b0);
        run_train("w0g0c2", 0, 0, 2, -1, -1, 1'b0);
        run_train("abort_w4", 4, 2, 3, 1, -1, 1'b0);
        run_train("rst_low_c5", 2, 3, 5, -1, 3, 1'b0);
        run_train("abort_start", 2, 1, 2, -1, -1, 1'b1);
        run_train("abort_in_fin", 1, 1, 1, 1, -1, 1'b0);
        run_train("max_wg", 255, 255, 2, -1, -1, 1'b0);
        run_train("max_count", 1, 1, 255, -1, -1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            w   = $urandom_range(0, 4);
            g   = $urandom_range(0, 4);
            c   = $urandom_range(0, 5);
            len = (c == 0) ? 1 : (c * ((w == 0) ? 1 : w) + (c - 1) * ((g == 0) ? 1 : g) + 1);
            ab  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len - 1);
            run_train($sformatf("rnd%0d", t), w, g, c, ab, -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
